// File: rtl/wtime_pkg.sv
// Shared constants, types and helpers for the wait-time estimator.
package wtime_pkg;

  localparam int P_W      = 3;
  localparam int T_MAX    = 3;
  localparam int T_W      = 2;
  localparam int WT_W     = 5;
  localparam int SVC_TIME = 2;

  localparam int DEPTH = T_MAX * (2 ** P_W);
  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [WT_W-1:0]  wt_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam wt_t WT_SAT = '1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Row-major table index; rows start at tcount=1.
  function automatic idx_t tbl_idx(input logic [T_W-1:0] t, input logic [P_W-1:0] p);
    int raw;
    raw = (int'(t) - 1) * (2 ** P_W) + int'(p);
    return raw[IDX_W-1:0];
  endfunction

  function automatic logic t_ok(input logic [T_W-1:0] t);
    return (int'(t) >= 1) && (int'(t) <= T_MAX);
  endfunction

endpackage

// File: rtl/wtime_init_seq.sv
// Walks every (tcount, pcount) cell once after reset and produces the
// default entry ceil(p/t)*SVC_TIME (saturated) without a divider.
module wtime_init_seq
  import wtime_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic             init_we,
  output idx_t             init_addr,
  output wt_t              init_data,
  output logic             init_last
);

  logic           active_q, active_d;
  logic [T_W-1:0] t_q, t_d;
  logic [P_W-1:0] p_q, p_d;
  logic [T_W-1:0] r_q, r_d;   // (p-1) mod t for the current column
  wt_t            acc_q, acc_d;

  logic           hit;
  logic           row_end;
  logic [WT_W:0]  sum;
  wt_t            acc_nxt;

  // Accumulator steps by SVC_TIME each time a new group of t people starts.
  always_comb begin
    hit       = (p_q != '0) && (r_q == '0);
    sum       = {1'b0, acc_q} + (hit ? (WT_W+1)'(SVC_TIME) : '0);
    acc_nxt   = (sum > {1'b0, WT_SAT}) ? WT_SAT : sum[WT_W-1:0];
    row_end   = (p_q == '1);
    init_last = active_q && row_end && (t_q == T_W'(T_MAX));
    init_we   = active_q;
    init_addr = tbl_idx(t_q, p_q);
    init_data = acc_nxt;

    active_d = active_q;
    t_d      = t_q;
    p_d      = p_q;
    r_d      = r_q;
    acc_d    = acc_q;
    if (active_q) begin
      if (row_end) begin
        p_d   = '0;
        r_d   = '0;
        acc_d = '0;
        t_d   = t_q + T_W'(1);
        if (init_last) active_d = 1'b0;
      end else begin
        p_d   = p_q + P_W'(1);
        acc_d = acc_nxt;
        if (p_q != '0) r_d = (r_q == t_q - T_W'(1)) ? '0 : r_q + T_W'(1);
      end
    end
  end

  // Walker registers; reset restarts the walk at row 1, column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b1;
      t_q      <= T_W'(1);
      p_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      t_q      <= t_d;
      p_q      <= p_d;
      r_q      <= r_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/wtime_table.sv
// Programmable queue wait-time table with valid/ready lookup and host writes.
// Optional countdown of the last looked-up wait time: define WTIME_COUNTDOWN_EN.
module wtime_table
  import wtime_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic             init_busy,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [T_W-1:0]   req_tcount,
  input  logic [P_W-1:0]   req_pcount,
  output logic             rsp_valid,
  output logic [WT_W-1:0]  rsp_wtime,
  output logic             rsp_err,
  input  logic             wr_en,
  input  logic [T_W-1:0]   wr_tcount,
  input  logic [P_W-1:0]   wr_pcount,
  input  logic [WT_W-1:0]  wr_data,
`ifdef WTIME_COUNTDOWN_EN
  input  logic             tick,
  output logic [WT_W-1:0]  cd_wtime,
  output logic             cd_done,
`endif
  output logic             wr_err
);

  logic [0:0] state_q, state_d;
  logic       init_we, init_last;
  idx_t       init_addr;
  wt_t        init_data;

  wtime_init_seq u_init (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_last (init_last)
  );

  logic accept, rd_en, host_we, ram_we, wr_err_d;
  idx_t ram_waddr;
  wt_t  ram_wdata;

  wt_t  mem [DEPTH];
  wt_t  rd_q;
  wt_t  hold_q;
  logic rsp_valid_q, rsp_err_q, wr_err_q;

  // Control decode and write-port mux (init walker owns the port during INIT).
  always_comb begin
    state_d   = (state_q == ST_INIT && init_last) ? ST_READY : state_q;
    init_busy = (state_q == ST_INIT);
    req_ready = (state_q == ST_READY);
    accept    = req_valid && req_ready;
    rd_en     = accept && t_ok(req_tcount);
    host_we   = wr_en && (state_q == ST_READY) && t_ok(wr_tcount);
    wr_err_d  = wr_en && !host_we;
    ram_we    = init_we || host_we;
    ram_waddr = init_we ? init_addr : tbl_idx(wr_tcount, wr_pcount);
    ram_wdata = init_we ? init_data : wr_data;
  end

  // FSM state and response/status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= accept;
      wr_err_q    <= wr_err_d;
      if (accept)      rsp_err_q <= !t_ok(req_tcount);
      if (rsp_valid_q) hold_q    <= rsp_wtime;
    end
  end

  // Table RAM: one write port, one sync read port; a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (rd_en)  rd_q <= mem[tbl_idx(req_tcount, req_pcount)];
  end

  // Response data is only meaningful while rsp_valid; otherwise the last value is held.
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    wr_err    = wr_err_q;
    if (rsp_valid_q) rsp_wtime = rsp_err_q ? '0 : rd_q;
    else             rsp_wtime = hold_q;
  end

`ifdef WTIME_COUNTDOWN_EN
  wt_t  cd_q, cd_d;
  logic cd_done_q;

  // Reload on a good response, otherwise count down on tick and stop at zero.
  always_comb begin
    cd_d = cd_q;
    if (rsp_valid_q && !rsp_err_q)  cd_d = rsp_wtime;
    else if (tick && cd_q != '0)    cd_d = cd_q - WT_W'(1);
  end

  // Countdown register and the 1->0 completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_q      <= '0;
      cd_done_q <= 1'b0;
    end else begin
      cd_q      <= cd_d;
      cd_done_q <= (cd_q == WT_W'(1)) && (cd_d == '0);
    end
  end

  assign cd_wtime = cd_q;
  assign cd_done  = cd_done_q;
`endif

endmodule
